// File: rtl/simple_ddr_burst_if.sv
// Host-side bus of the burst-mode memory front-end: write/read command and data
// streams plus status. Master drives commands, slave is the memory.
interface simple_ddr_burst_if #(
   parameter int DATA_WIDTH = 128
);
   logic                    wr_addr_en;
   logic [31:0]             wr_addr;
   logic                    wr_en;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [DATA_WIDTH/8-1:0] wr_datamask;
   logic                    wr_busy;
   logic                    wr_ack;
   logic                    rd_addr_en;
   logic [31:0]             rd_addr;
   logic                    rd_busy;
   logic                    rd_en;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic                    rd_valid;
   logic                    rd_ack;
   logic                    ovf_err;

   modport master (
      output wr_addr_en, wr_addr, wr_en, wr_data, wr_datamask, rd_addr_en, rd_addr, rd_en,
      input  wr_busy, wr_ack, rd_busy, rd_data, rd_valid, rd_ack, ovf_err
   );

   modport slave (
      input  wr_addr_en, wr_addr, wr_en, wr_data, wr_datamask, rd_addr_en, rd_addr, rd_en,
      output wr_busy, wr_ack, rd_busy, rd_data, rd_valid, rd_ack, ovf_err
   );
endinterface

// File: rtl/simple_ddr_burst.sv
// Burst-mode behavioural DDR stand-in: command/data FIFOs, round-robin burst FSM,
// byte-masked dual-port RAM and a credit-protected read-data FIFO.
module simple_ddr_burst_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic [CW-1:0] count,
   output logic          ovf
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic          full, do_push, do_pop;

   // a push into a full FIFO still lands if a pop frees a slot on the same edge
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign do_push = push && (!full || do_pop);
   assign ovf     = push && !do_push;
   assign dout    = mem[rp];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
         if (do_pop)  rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end
endmodule

module simple_ddr_burst #(
   parameter int DATA_WIDTH  = 128,
   parameter int BURST_LEN   = 8,
   parameter int MEM_DEPTH   = 4096,
   parameter int CMD_DEPTH   = 16,
   parameter int WDATA_DEPTH = 64,
   parameter int RDATA_DEPTH = 64,
   parameter int RD_LATENCY  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   simple_ddr_burst_if.slave  bus
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF   = $clog2(BYTES);
   localparam int MAW   = $clog2(MEM_DEPTH);
   localparam int BW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int CCW   = $clog2(CMD_DEPTH + 1);
   localparam int WCW   = $clog2(WDATA_DEPTH + 1);
   localparam int RCW   = $clog2(RDATA_DEPTH + 1);
   localparam int LW    = $clog2(RD_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

   state_t                state, state_nxt;
   logic [BW-1:0]         beat_cnt;
   logic [MAW-1:0]        cur_idx, wcmd_idx, rcmd_idx;
   logic                  last_wr, last_beat, wr_elig, rd_elig;
   logic                  wcmd_pop, rcmd_pop, wdat_pop, rd_issue;
   logic                  wcmd_ovf, rcmd_ovf, wdat_ovf, rdat_ovf;
   logic [CCW-1:0]        wcmd_cnt, rcmd_cnt;
   logic [WCW-1:0]        wdat_cnt;
   logic [RCW-1:0]        rdat_cnt;
   logic [BYTES+DATA_WIDTH-1:0] wdat_word;
   logic [DATA_WIDTH-1:0] wdat_data, rdat_head;
   logic [BYTES-1:0]      wdat_mask;
   logic [RD_LATENCY:1]   vld_pipe;
   logic [DATA_WIDTH-1:0] dat_pipe [1:RD_LATENCY];
   logic [LW-1:0]         in_flight;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   simple_ddr_burst_fifo #(.W(MAW), .DEPTH(CMD_DEPTH)) u_wcmd (
      .clk(clk), .rst_n(rst_n), .push(bus.wr_addr_en), .din(bus.wr_addr[OFF +: MAW]),
      .pop(wcmd_pop), .dout(wcmd_idx), .count(wcmd_cnt), .ovf(wcmd_ovf));

   simple_ddr_burst_fifo #(.W(BYTES + DATA_WIDTH), .DEPTH(WDATA_DEPTH)) u_wdat (
      .clk(clk), .rst_n(rst_n), .push(bus.wr_en), .din({bus.wr_datamask, bus.wr_data}),
      .pop(wdat_pop), .dout(wdat_word), .count(wdat_cnt), .ovf(wdat_ovf));

   simple_ddr_burst_fifo #(.W(MAW), .DEPTH(CMD_DEPTH)) u_rcmd (
      .clk(clk), .rst_n(rst_n), .push(bus.rd_addr_en), .din(bus.rd_addr[OFF +: MAW]),
      .pop(rcmd_pop), .dout(rcmd_idx), .count(rcmd_cnt), .ovf(rcmd_ovf));

   simple_ddr_burst_fifo #(.W(DATA_WIDTH), .DEPTH(RDATA_DEPTH)) u_rdat (
      .clk(clk), .rst_n(rst_n), .push(vld_pipe[RD_LATENCY]), .din(dat_pipe[RD_LATENCY]),
      .pop(bus.rd_en), .dout(rdat_head), .count(rdat_cnt), .ovf(rdat_ovf));

   assign wdat_mask   = wdat_word[BYTES+DATA_WIDTH-1:DATA_WIDTH];
   assign wdat_data   = wdat_word[DATA_WIDTH-1:0];
   assign bus.wr_busy = (wcmd_cnt == CCW'(CMD_DEPTH)) || (wdat_cnt == WCW'(WDATA_DEPTH));
   assign bus.rd_busy = (rcmd_cnt == CCW'(CMD_DEPTH));

   always_comb begin
      in_flight = '0;
      for (int s = 1; s <= RD_LATENCY; s++) in_flight = in_flight + LW'(vld_pipe[s]);
   end

   // Read credit counts beats already queued and beats still in the RAM pipe,
   // so the read-data FIFO can never be pushed while full.
   always_comb begin
      state_nxt = state;
      wcmd_pop  = 1'b0;
      rcmd_pop  = 1'b0;
      wdat_pop  = 1'b0;
      rd_issue  = 1'b0;
      last_beat = (beat_cnt == BW'(BURST_LEN - 1));
      wr_elig   = (wcmd_cnt != '0) && (int'(wdat_cnt) >= BURST_LEN);
      rd_elig   = (rcmd_cnt != '0) &&
                  (int'(rdat_cnt) + int'(in_flight) + BURST_LEN <= RDATA_DEPTH);
      case (state)
         IDLE: begin
            if (wr_elig && (!rd_elig || !last_wr)) begin
               state_nxt = WR_BURST;
               wcmd_pop  = 1'b1;
            end else if (rd_elig) begin
               state_nxt = RD_BURST;
               rcmd_pop  = 1'b1;
            end
         end
         WR_BURST: begin
            wdat_pop = 1'b1;
            if (last_beat) state_nxt = IDLE;
         end
         RD_BURST: begin
            rd_issue = 1'b1;
            if (last_beat) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         beat_cnt <= '0;
         cur_idx  <= '0;
         last_wr  <= 1'b0;
         vld_pipe <= '0;
      end else begin
         state <= state_nxt;
         if (wcmd_pop) begin
            cur_idx <= wcmd_idx;
            last_wr <= 1'b1;
         end else if (rcmd_pop) begin
            cur_idx <= rcmd_idx;
            last_wr <= 1'b0;
         end else if (state != IDLE) begin
            cur_idx <= cur_idx + 1'b1;
         end
         if (state != IDLE) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
         vld_pipe[1] <= rd_issue;
         for (int s = 2; s <= RD_LATENCY; s++) vld_pipe[s] <= vld_pipe[s-1];
      end
   end

   // RAM and read data pipe carry no reset; validity lives in vld_pipe
   always_ff @(posedge clk) begin
      if (state == WR_BURST) begin
         for (int b = 0; b < BYTES; b++)
            if (!wdat_mask[b]) mem[cur_idx][8*b +: 8] <= wdat_data[8*b +: 8];
      end
      dat_pipe[1] <= mem[cur_idx];
      for (int s = 2; s <= RD_LATENCY; s++) dat_pipe[s] <= dat_pipe[s-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.wr_ack   <= 1'b0;
         bus.rd_ack   <= 1'b0;
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= '0;
         bus.ovf_err  <= 1'b0;
      end else begin
         bus.wr_ack   <= bus.wr_en && !wdat_ovf;
         bus.rd_ack   <= vld_pipe[RD_LATENCY];
         bus.rd_valid <= bus.rd_en && (rdat_cnt != '0);
         if (bus.rd_en && (rdat_cnt != '0)) bus.rd_data <= rdat_head;
         bus.ovf_err  <= bus.ovf_err | wcmd_ovf | wdat_ovf | rcmd_ovf | rdat_ovf;
      end
   end
endmodule
